// File: rtl/conv_output_streamer.sv
// conv_output_streamer: buffers PE output pixels in a small FIFO and
// emits one output-channel image as an AXI4-Stream master burst.
module conv_output_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [7:0]            IMAGE_SIZE,
  input  logic                  PE_out_valid,
  input  logic [DATA_WIDTH-1:0] PE_out_data,
  output logic                  PE_out_ready,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  Done_row_out,
  output logic                  Done_stream,
  output logic                  Streamer_IDLE
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_Idle,
    S_Stream,
    S_Done
  } state_t;

  state_t state, state_n;

  logic [7:0]            size_q;
  logic [14:0]           total_q;
  logic [14:0]           total_n;
  logic [14:0]           in_cnt;
  logic [14:0]           out_cnt;
  logic [7:0]            col_cnt;
  logic [AW:0]           fifo_cnt;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic streaming;
  logic arm;
  logic wr_en;
  logic rd_en;
  logic last_beat;
  logic row_end;

  assign total_n   = 15'(IMAGE_SIZE) * 15'(IMAGE_SIZE);
  assign streaming = (state == S_Stream);
  assign arm       = (state == S_Idle) && Start;

  // Ready looks only at registered occupancy, so a full FIFO stays
  // closed for the cycle in which it is drained.
  assign PE_out_ready  = streaming && (fifo_cnt != FULL)
                       && (in_cnt != total_q);
  assign m_axis_tvalid = streaming && (fifo_cnt != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;

  assign wr_en     = PE_out_valid && PE_out_ready;
  assign rd_en     = m_axis_tvalid && m_axis_tready;
  assign last_beat = (out_cnt == total_q - 15'd1);
  assign row_end   = (col_cnt == size_q - 8'd1);

  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign Done_row_out  = rd_en && row_end;
  assign Done_stream   = (state == S_Done);
  assign Streamer_IDLE = (state == S_Idle);

  always_comb begin
    state_n = state;
    unique case (state)
      S_Idle:   if (Start) state_n = S_Stream;
      S_Stream: if (rd_en && last_beat) state_n = S_Done;
      S_Done:   state_n = S_Idle;
      default:  state_n = S_Idle;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_Idle;
      size_q   <= '0;
      total_q  <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      col_cnt  <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_n;
      if (arm) begin
        size_q   <= IMAGE_SIZE;
        total_q  <= total_n;
        in_cnt   <= '0;
        out_cnt  <= '0;
        col_cnt  <= '0;
        fifo_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          in_cnt <= in_cnt + 15'd1;
        end
        if (rd_en) begin
          rd_ptr  <= rd_ptr + 1'b1;
          out_cnt <= out_cnt + 15'd1;
          col_cnt <= row_end ? 8'd0 : col_cnt + 8'd1;
        end
        case ({wr_en, rd_en})
          2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
          2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
          default: fifo_cnt <= fifo_cnt;
        endcase
      end
    end
  end

  // Storage needs no reset: the read side is gated by fifo_cnt.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= PE_out_data;
  end

endmodule

// File: tb/tb_conv_output_streamer.sv
// Scoreboard bench for conv_output_streamer: directed images,
// expected beats queued at issue time, popped by a negedge monitor.
module tb_conv_output_streamer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [7:0]    IMAGE_SIZE;
  logic          PE_out_valid;
  logic [DW-1:0] PE_out_data;
  logic          PE_out_ready;
  logic          m_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          Done_row_out;
  logic          Done_stream;
  logic          Streamer_IDLE;

  conv_output_streamer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(16)
  ) dut (
    .clk          (clk),
    .Reset        (Reset),
    .Start        (Start),
    .IMAGE_SIZE   (IMAGE_SIZE),
    .PE_out_valid (PE_out_valid),
    .PE_out_data  (PE_out_data),
    .PE_out_ready (PE_out_ready),
    .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .Done_row_out (Done_row_out),
    .Done_stream  (Done_stream),
    .Streamer_IDLE(Streamer_IDLE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        row;
  } beat_t;

  beat_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int lasts = 0;
  int rows = 0;
  int acc_total = 0;
  bit rnd_done = 1'b0;

  bit          pend_done = 1'b0;
  bit          stall = 1'b0;
  logic [31:0] sdata;
  logic        slast;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within budget", name);
  endtask

  task automatic push_image(input int n, input int base);
    beat_t b;
    for (int i = 0; i < n * n; i++) begin
      b.data = base + i;
      b.last = (i == n * n - 1);
      b.row  = ((i % n) == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic reset_checks();
    chk("rst_ready", PE_out_ready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_row", Done_row_out, 0);
    chk("rst_done", Done_stream, 0);
    chk("rst_idle", Streamer_IDLE, 1);
  endtask

  task automatic start(input int n);
    @(posedge clk); #1;
    Start = 1'b1;
    IMAGE_SIZE = n[7:0];
    @(posedge clk); #1;
    Start = 1'b0;
    chk("idle_after_start", Streamer_IDLE, 0);
    chk("ready_after_start", PE_out_ready, 1);
  endtask

  task automatic feed(input int n, input int base, input int vprob);
    int sent = 0;
    for (int g = 0; g < 100000 && sent < n; g++) begin
      @(posedge clk); #1;
      PE_out_valid = ($urandom_range(99) < vprob);
      PE_out_data = base + sent;
      @(negedge clk);
      if (PE_out_valid && PE_out_ready) begin
        sent++;
        acc_total++;
      end
    end
    @(posedge clk); #1;
    PE_out_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (Done_stream) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail("done_timeout");
    else begin
      @(negedge clk);
      chk("idle_after_done", Streamer_IDLE, 1);
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (Reset) begin
      pend_done = 1'b0;
      stall = 1'b0;
    end else begin
      if (pend_done || Done_stream)
        chk("done_stream_timing", Done_stream, pend_done);
      pend_done = 1'b0;
      if (stall) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_tdata", m_axis_tdata, sdata);
        chk("stall_tlast", m_axis_tlast, slast);
      end
      stall = m_axis_tvalid && !m_axis_tready;
      sdata = m_axis_tdata;
      slast = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %0h expected none", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_axis_tdata, e.data);
          chk("beat_tlast", m_axis_tlast, e.last);
          chk("beat_row_end", Done_row_out, e.row);
        end
        beats++;
        if (m_axis_tlast) begin
          lasts++;
          pend_done = 1'b1;
        end
        if (Done_row_out) rows++;
      end else if (Done_row_out) begin
        checks++;
        errors++;
        $display("FAIL row_no_beat: got 1 expected 0");
      end
    end
  end

  initial begin
    int b0, r0, l0, a0;
    Reset = 1'b1;
    Start = 1'b0;
    IMAGE_SIZE = 8'd4;
    PE_out_valid = 1'b0;
    PE_out_data = '0;
    m_axis_tready = 1'b0;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;

    // 4x4, back-to-back pixels, sink always ready
    m_axis_tready = 1'b1;
    b0 = beats; r0 = rows; l0 = lasts;
    push_image(4, 1);
    start(4);
    fork feed(16, 1, 100); join_none
    wait_done(200);
    chk("t1_beats", beats - b0, 16);
    chk("t1_rows", rows - r0, 4);
    chk("t1_lasts", lasts - l0, 1);

    // 8x8 with a long sink stall: FIFO fills, then drains
    m_axis_tready = 1'b0;
    b0 = beats;
    push_image(8, 1);
    start(8);
    a0 = acc_total;
    fork feed(64, 1, 100); join_none
    repeat (40) @(posedge clk);
    #1;
    chk("t2_accepts_full", acc_total - a0, 16);
    chk("t2_ready_full", PE_out_ready, 0);
    chk("t2_tvalid_held", m_axis_tvalid, 1);
    chk("t2_tdata_head", m_axis_tdata, 1);
    m_axis_tready = 1'b1;
    @(negedge clk);
    chk("t2_ready_same_cycle", PE_out_ready, 0);
    @(negedge clk);
    chk("t2_ready_reopen", PE_out_ready, 1);
    wait_done(300);
    chk("t2_beats", beats - b0, 64);

    // 128x128 with random valid and ready
    b0 = beats; r0 = rows; l0 = lasts;
    push_image(128, 1000);
    start(128);
    rnd_done = 1'b0;
    fork
      begin
        feed(16384, 1000, 75);
        @(posedge clk); #1;
        PE_out_valid = 1'b1;
        @(negedge clk);
        chk("t4_ready_after_total", PE_out_ready, 0);
        PE_out_valid = 1'b0;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          if (!rnd_done) m_axis_tready = ($urandom_range(1) == 1);
        end
      end
    join_none
    wait_done(90000);
    rnd_done = 1'b1;
    @(posedge clk); #2;
    m_axis_tready = 1'b1;
    chk("t4_beats", beats - b0, 16384);
    chk("t4_rows", rows - r0, 128);
    chk("t4_lasts", lasts - l0, 1);

    // reset after beat 10 of a 4x4 image
    m_axis_tready = 1'b0;
    push_image(4, 100);
    start(4);
    feed(16, 100, 100);
    b0 = beats;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (beats - b0 == 10) break;
    end
    chk("t5_beats_before_reset", beats - b0, 10);
    #1 Reset = 1'b1;
    #1;
    reset_checks();
    exp_q.delete();
    @(posedge clk); #1;
    Reset = 1'b0;
    b0 = beats;
    push_image(4, 200);
    start(4);
    fork feed(16, 200, 100); join_none
    wait_done(200);
    chk("t5_clean_beats", beats - b0, 16);

    // Start with a new size pulsed mid-image is ignored
    b0 = beats; l0 = lasts;
    push_image(4, 300);
    start(4);
    fork feed(16, 300, 100); join_none
    repeat (5) @(posedge clk);
    #1;
    Start = 1'b1;
    IMAGE_SIZE = 8'd8;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("t6_still_streaming", Streamer_IDLE, 0);
    wait_done(200);
    chk("t6_beats", beats - b0, 16);
    chk("t6_lasts", lasts - l0, 1);
    repeat (3) @(negedge clk);
    chk("t6_quiet_after", m_axis_tvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
